rv32i_cpu: RTL and testbench

- Single-cycle RV32I integer core: one instruction fetched, decoded, executed and retired per clock.
- Contains its own instruction ROM (instance I_mem, array ROM) and data RAM (instance D_mem, array RAM).
- It is the top of the processor; the bench preloads programs by writing I_mem.ROM directly.
- No external bus. All state is observed hierarchically: pc, regs[0:31], D_mem.RAM.

---
 rtl/rv32i_pkg.sv | 63 ++++++
 rtl/rv32i_cpu_if.sv | 12 +
 rtl/rv32i_alu.sv | 39 +++
 rtl/rv32i_mem.sv | 44 ++++
 rtl/rv32i_cpu.sv | 165 ++++++++++++++++
 tb/tb_rv32i_cpu.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings (opcodes, funct3 codes) and ALU operation type.
// Imported by every file of the rv32i_cpu core.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  // sub_sel only matters for register-register ADD/SUB; sra_sel picks SRA over SRL.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic sub_sel,
                                         input logic sra_sel);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = sub_sel ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = sra_sel ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_cpu_if.sv
// Data-memory bus between the rv32i_cpu datapath and its data RAM.
// Combinational read data; byte-enabled write committed on the clock edge.
interface rv32i_cpu_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic        we;

  modport master (output addr, wdata, be, we, input rdata);
  modport slave  (input addr, wdata, be, we, output rdata);
endinterface

// File: rtl/rv32i_alu.sv
// RV32I ALU: one result per alu_op_t plus the equality and signed/unsigned
// less-than flags the branch unit consumes.
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     op_i,
  output logic [31:0] y_o,
  output logic        eq_o,
  output logic        lt_o,
  output logic        ltu_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  assign eq_o  = (a_i == b_i);
  assign lt_o  = ($signed(a_i) < $signed(b_i));
  assign ltu_o = (a_i < b_i);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SLT:  y_o = {31'b0, lt_o};
      ALU_SLTU: y_o = {31'b0, ltu_o};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_mem.sv
// Instruction ROM and byte-enabled data RAM of the rv32i_cpu core. Both are
// plain arrays (ROM, RAM) so a bench can preload them hierarchically.
module rv32i_rom #(
  parameter int WORDS = 256
) (
  input  logic [31:0] addr_i,
  output logic [31:0] instr_o
);

  localparam int AW = $clog2(WORDS);

  logic [31:0] ROM [0:WORDS-1];
  logic        unused_addr;

  assign instr_o     = ROM[addr_i[AW+1:2]];
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

endmodule

module rv32i_ram #(
  parameter int WORDS = 256
) (
  input logic         clk,
  rv32i_cpu_if.slave  bus
);

  localparam int AW = $clog2(WORDS);

  logic [31:0]   RAM [0:WORDS-1];
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign idx         = bus.addr[AW+1:2];
  assign bus.rdata   = RAM[idx];
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  // NOTE: memory arrays carry no reset; contents survive core reset by design.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.we && bus.be[i]) RAM[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core with internal ROM (I_mem) and RAM (D_mem).
// Define CPU_TRACE_EN to $display every retired instruction.
module rv32i_cpu
  import rv32i_pkg::*;
#(
  parameter int          ROM_WORDS = 256,
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n
);

  // rst_n is an active-high synchronous reset despite its name.
  logic rst;
  assign rst = rst_n;

  logic [31:0] pc;
  logic [31:0] regs [0:31];
  logic [31:0] pc_d, pc_plus4, instr;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_t     alu_op;
  logic        alu_eq, alu_lt, alu_ltu;

  logic        rd_we;
  logic [31:0] rd_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        branch_taken;
  logic        load_ok;
  logic [31:0] load_data, lane_shift;
  logic [15:0] half_sel;

  rv32i_rom #(.WORDS(ROM_WORDS)) I_mem (.addr_i(pc), .instr_o(instr));

  rv32i_cpu_if dmem ();
  rv32i_ram #(.WORDS(RAM_WORDS)) D_mem (.clk(clk), .bus(dmem));

  rv32i_alu u_alu (
    .a_i(alu_a), .b_i(alu_b), .op_i(alu_op),
    .y_o(alu_y), .eq_o(alu_eq), .lt_o(alu_lt), .ltu_o(alu_ltu)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign pc_plus4 = pc + 32'd4;

  // Nothing may land in RAM while the core is held in reset.
  assign dmem.addr  = alu_y;
  assign dmem.wdata = mem_wdata;
  assign dmem.be    = mem_be;
  assign dmem.we    = mem_we & ~rst;

  always_comb begin
    case (funct3)
      F3_BEQ:  branch_taken = alu_eq;
      F3_BNE:  branch_taken = ~alu_eq;
      F3_BLT:  branch_taken = alu_lt;
      F3_BGE:  branch_taken = ~alu_lt;
      F3_BLTU: branch_taken = alu_ltu;
      F3_BGEU: branch_taken = ~alu_ltu;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    lane_shift = dmem.rdata >> {alu_y[1:0], 3'b000};
    half_sel   = alu_y[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    load_ok    = 1'b1;
    case (funct3)
      F3_LB:   load_data = {{24{lane_shift[7]}}, lane_shift[7:0]};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data = dmem.rdata;
      F3_LBU:  load_data = {24'b0, lane_shift[7:0]};
      F3_LHU:  load_data = {16'b0, half_sel};
      default: begin load_data = '0; load_ok = 1'b0; end
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    alu_a     = rs1_val;
    alu_b     = rs2_val;
    alu_op    = ALU_ADD;
    pc_d      = pc_plus4;
    rd_we     = 1'b0;
    rd_wdata  = alu_y;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = rs2_val;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
      OP_AUIPC: begin alu_a = pc; alu_b = imm_u; rd_we = 1'b1; end
      OP_JAL:   begin rd_we = 1'b1; rd_wdata = pc_plus4; pc_d = pc + imm_j; end
      OP_JALR:  begin
        alu_b    = imm_i;
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_d     = {alu_y[31:1], 1'b0};
      end
      OP_BRANCH: if (branch_taken) pc_d = pc + imm_b;
      OP_LOAD:  begin alu_b = imm_i; rd_we = load_ok; rd_wdata = load_data; end
      OP_STORE: begin
        alu_b = imm_s;
        case (funct3)
          F3_SB: begin
            mem_we = 1'b1; mem_be = 4'b0001 << alu_y[1:0]; mem_wdata = {4{rs2_val[7:0]}};
          end
          F3_SH: begin
            mem_we = 1'b1; mem_be = alu_y[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{rs2_val[15:0]}};
          end
          F3_SW:   begin mem_we = 1'b1; mem_be = 4'b1111; end
          default: ;
        endcase
      end
      OP_IMM:   begin alu_b = imm_i; alu_op = alu_decode(funct3, 1'b0, funct7[5]); rd_we = 1'b1; end
      OP_REG:   begin alu_op = alu_decode(funct3, funct7[5], funct7[5]); rd_we = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= pc_d;
      if (rd_we && (rd != 5'd0)) regs[rd] <= rd_wdata;
    end
  end

`ifdef CPU_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (rd_we && (rd != 5'd0))
        $display("pc=%08h instr=%08h rd=x%0d val=%08h", pc, instr, rd, rd_wdata);
      else
        $display("pc=%08h instr=%08h rd=-", pc, instr);
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_cpu.sv
// Directed bench for rv32i_cpu: preloads small programs into I_mem.ROM and
// checks pc, registers and D_mem.RAM against hand-computed values.
module tb_rv32i_cpu;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] CALL_PC [19] = '{
    32'd0, 32'd20, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd8, 32'd12, 32'd16,
    32'd20, 32'd12, 32'd16, 32'd20, 32'd16, 32'd20, 32'd20, 32'd24, 32'd0
  };
  localparam logic [31:0] BR_PC [13] = '{
    32'd0, 32'd4, 32'd8, 32'd20, 32'd24, 32'd28, 32'd40, 32'd32, 32'd36, 32'd48,
    32'd52, 32'd56, 32'd60
  };

  always #5 clk = ~clk;

  rv32i_cpu #(.ROM_WORDS(256), .RAM_WORDS(256), .RESET_PC(32'h0)) dut (
    .clk  (clk),
    .rst_n(rst_n)
  );

  // Small assembler helpers so programs read as instructions.
  function automatic logic [31:0] f_i(input logic [31:0] imm, input logic [31:0] rs1,
                                      input logic [2:0] f3, input logic [31:0] rd,
                                      input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
  endfunction
  function automatic logic [31:0] f_addi(input logic [31:0] rd, input logic [31:0] rs1,
                                         input logic [31:0] imm);
    return f_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [31:0] rs2,
                                      input logic [31:0] rs1, input logic [2:0] f3,
                                      input logic [31:0] rd);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] f_lui(input logic [31:0] rd, input logic [31:0] imm20);
    return {imm20[19:0], rd[4:0], 7'h37};
  endfunction
  function automatic logic [31:0] f_st(input logic [2:0] f3, input logic [31:0] rs2,
                                       input logic [31:0] rs1, input logic [31:0] imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] f_br(input logic [2:0] f3, input logic [31:0] rs1,
                                       input logic [31:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] f_jal(input logic [31:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) dut.I_mem.ROM[i] = NOP;
  endtask

  // Two reset edges, then release so the next edge retires ROM[0].
  task automatic start();
    rst_n = 1'b1;
    step();
    step();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    dut.I_mem.ROM[0] = f_addi(5, 0, 9);
    dut.I_mem.ROM[1] = f_addi(6, 5, 1);
    rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      total++;
      if (dut.pc !== 32'd0) begin
        bad++; $display("FAIL reset_pc edge%0d got=%h want=%h", e, dut.pc, 32'd0);
      end
    end
    for (int r = 1; r < 32; r++) begin
      total++;
      if (dut.regs[r] !== 32'd0) begin
        bad++; $display("FAIL reset_x%0d got=%h want=%h", r, dut.regs[r], 32'd0);
      end
    end
    rst_n = 1'b0;
    step();
    total++;
    if (dut.regs[5] !== 32'd9 || dut.pc !== 32'd4) begin
      bad++; $display("FAIL first_retire got x5=%h pc=%h want x5=9 pc=4", dut.regs[5], dut.pc);
    end
    step();
    total++;
    if (dut.regs[6] !== 32'd10) begin
      bad++; $display("FAIL second_retire got=%h want=%h", dut.regs[6], 32'd10);
    end
  endtask

  task automatic test_call_return();
    clear_rom();
    dut.I_mem.ROM[0] = 32'h014000EF;
    for (int i = 1; i <= 4; i++) dut.I_mem.ROM[i] = 32'hFFC08093;
    dut.I_mem.ROM[5] = 32'h000080E7;
    dut.I_mem.ROM[6] = 32'hFE9FF0EF;
    dut.I_mem.ROM[7] = 32'h00190913;
    start();
    total++;
    if (dut.pc !== CALL_PC[0]) begin
      bad++; $display("FAIL call_pc0 got=%h want=%h", dut.pc, CALL_PC[0]);
    end
    for (int k = 1; k < 19; k++) begin
      step();
      total++;
      if (dut.pc !== CALL_PC[k]) begin
        bad++; $display("FAIL call_pc%0d got=%h want=%h", k, dut.pc, CALL_PC[k]);
      end
      if (CALL_PC[k-1] == 32'd20) begin
        total++;
        if (dut.regs[1] !== 32'd24) begin
          bad++; $display("FAIL jalr_link%0d got=%h want=%h", k, dut.regs[1], 32'd24);
        end
      end
    end
    total++;
    if (dut.regs[1] !== 32'd28) begin
      bad++; $display("FAIL jal_link got=%h want=%h", dut.regs[1], 32'd28);
    end
    total++;
    if (dut.regs[18] !== 32'd0) begin
      bad++; $display("FAIL call_x18 got=%h want=%h", dut.regs[18], 32'd0);
    end
  endtask

  task automatic test_alu();
    clear_rom();
    for (int i = 0; i < 10; i++) dut.I_mem.ROM[i] = f_addi(18, 18, 1);
    dut.I_mem.ROM[10] = f_addi(18, 18, -5);
    dut.I_mem.ROM[11] = f_lui(19, 1);
    dut.I_mem.ROM[12] = f_r(7'h20, 18, 19, 3'd0, 20);
    start();
    repeat (10) step();
    total++;
    if (dut.regs[18] !== 32'd10) begin
      bad++; $display("FAIL alu_x18_mid got=%h want=%h", dut.regs[18], 32'd10);
    end
    repeat (3) step();
    total++;
    if (dut.regs[18] !== 32'd5) begin
      bad++; $display("FAIL alu_x18 got=%h want=%h", dut.regs[18], 32'd5);
    end
    total++;
    if (dut.regs[19] !== 32'h0000_1000) begin
      bad++; $display("FAIL alu_lui got=%h want=%h", dut.regs[19], 32'h1000);
    end
    total++;
    if (dut.regs[20] !== 32'h0000_0FFB) begin
      bad++; $display("FAIL alu_sub got=%h want=%h", dut.regs[20], 32'h0FFB);
    end
    total++;
    if (dut.pc !== 32'd52) begin
      bad++; $display("FAIL alu_pc got=%h want=%h", dut.pc, 32'd52);
    end
  endtask

  task automatic test_signed();
    int          idx [8];
    logic [31:0] exp_v [8];
    clear_rom();
    dut.I_mem.ROM[0] = f_addi(5, 0, -1);
    dut.I_mem.ROM[1] = f_addi(6, 0, 1);
    dut.I_mem.ROM[2] = f_r(7'h00, 6, 5, 3'd2, 7);
    dut.I_mem.ROM[3] = f_r(7'h00, 6, 5, 3'd3, 8);
    dut.I_mem.ROM[4] = f_lui(9, 32'h80000);
    dut.I_mem.ROM[5] = f_i(32'h404, 9, 3'd5, 10, 7'h13);
    dut.I_mem.ROM[6] = f_i(32'h004, 9, 3'd5, 11, 7'h13);
    dut.I_mem.ROM[7] = f_i(32'd0, 5, 3'd2, 12, 7'h13);
    dut.I_mem.ROM[8] = f_i(-1, 6, 3'd3, 13, 7'h13);
    dut.I_mem.ROM[9] = f_r(7'h20, 6, 9, 3'd5, 14);
    start();
    repeat (10) step();
    idx   = '{7, 8, 9, 10, 11, 12, 13, 14};
    exp_v = '{32'd1, 32'd0, 32'h8000_0000, 32'hF800_0000, 32'h0800_0000,
              32'd1, 32'd1, 32'hC000_0000};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dut.regs[idx[i]] !== exp_v[i]) begin
        bad++; $display("FAIL signed_x%0d got=%h want=%h", idx[i], dut.regs[idx[i]], exp_v[i]);
      end
    end
  endtask

  task automatic test_memory();
    int          idx [8];
    logic [31:0] exp_v [8];
    clear_rom();
    dut.I_mem.ROM[0]  = f_lui(5, 32'h80818);
    dut.I_mem.ROM[1]  = f_addi(5, 5, 32'h283);
    dut.I_mem.ROM[2]  = f_st(3'd2, 5, 0, 8);
    dut.I_mem.ROM[3]  = f_i(8, 0, 3'd0, 6, 7'h03);
    dut.I_mem.ROM[4]  = f_i(8, 0, 3'd4, 7, 7'h03);
    dut.I_mem.ROM[5]  = f_i(10, 0, 3'd1, 8, 7'h03);
    dut.I_mem.ROM[6]  = f_addi(9, 0, 32'h55);
    dut.I_mem.ROM[7]  = f_st(3'd0, 9, 0, 9);
    dut.I_mem.ROM[8]  = f_i(8, 0, 3'd2, 10, 7'h03);
    dut.I_mem.ROM[9]  = f_i(10, 0, 3'd5, 11, 7'h03);
    dut.I_mem.ROM[10] = f_i(1032, 0, 3'd2, 12, 7'h03);
    dut.I_mem.ROM[11] = f_st(3'd1, 9, 0, 13);
    dut.I_mem.ROM[12] = f_i(11, 0, 3'd0, 13, 7'h03);
    start();
    repeat (13) step();
    idx   = '{5, 6, 7, 8, 10, 11, 12, 13};
    exp_v = '{32'h8081_8283, 32'hFFFF_FF83, 32'h0000_0083, 32'hFFFF_8081,
              32'h8081_5583, 32'h0000_8081, 32'h8081_5583, 32'hFFFF_FF80};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dut.regs[idx[i]] !== exp_v[i]) begin
        bad++; $display("FAIL mem_x%0d got=%h want=%h", idx[i], dut.regs[idx[i]], exp_v[i]);
      end
    end
    total++;
    if (dut.D_mem.RAM[2] !== 32'h8081_5583) begin
      bad++; $display("FAIL mem_ram2 got=%h want=%h", dut.D_mem.RAM[2], 32'h80815583);
    end
    total++;
    if (dut.D_mem.RAM[3][15:0] !== 16'h0055) begin
      bad++; $display("FAIL mem_sh_misaligned got=%h want=%h", dut.D_mem.RAM[3][15:0], 16'h0055);
    end
  endtask

  task automatic test_branch_x0();
    clear_rom();
    dut.I_mem.ROM[0]  = f_addi(5, 0, 1);
    dut.I_mem.ROM[1]  = f_addi(6, 0, 1);
    dut.I_mem.ROM[2]  = f_br(3'd0, 5, 6, 12);
    dut.I_mem.ROM[3]  = f_addi(7, 0, 1);
    dut.I_mem.ROM[4]  = f_addi(7, 0, 2);
    dut.I_mem.ROM[5]  = f_br(3'd0, 5, 0, 8);
    dut.I_mem.ROM[6]  = f_addi(0, 0, 7);
    dut.I_mem.ROM[7]  = f_br(3'd0, 0, 0, 12);
    dut.I_mem.ROM[8]  = f_addi(8, 0, 3);
    dut.I_mem.ROM[9]  = f_jal(0, 12);
    dut.I_mem.ROM[10] = f_br(3'd0, 5, 6, -8);
    dut.I_mem.ROM[11] = f_addi(7, 0, 5);
    dut.I_mem.ROM[12] = f_br(3'd1, 5, 6, -8);
    dut.I_mem.ROM[13] = f_addi(9, 0, 9);
    dut.I_mem.ROM[14] = f_r(7'h00, 5, 0, 3'd0, 10);
    start();
    for (int k = 1; k < 13; k++) begin
      step();
      total++;
      if (dut.pc !== BR_PC[k]) begin
        bad++; $display("FAIL branch_pc%0d got=%h want=%h", k, dut.pc, BR_PC[k]);
      end
    end
    total++;
    if (dut.regs[0] !== 32'd0) begin
      bad++; $display("FAIL x0_write got=%h want=%h", dut.regs[0], 32'd0);
    end
    total++;
    if (dut.regs[10] !== 32'd1) begin
      bad++; $display("FAIL x0_read got=%h want=%h", dut.regs[10], 32'd1);
    end
    total++;
    if (dut.regs[7] !== 32'd0 || dut.regs[8] !== 32'd3 || dut.regs[9] !== 32'd9) begin
      bad++; $display("FAIL branch_regs got x7=%h x8=%h x9=%h want 0 3 9",
                      dut.regs[7], dut.regs[8], dut.regs[9]);
    end
  endtask

  initial begin
    test_reset();
    test_call_return();
    test_alu();
    test_signed();
    test_memory();
    test_branch_x0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
